// File: rtl/wb_cpu_pkg.sv
// Shared types and constants for the CPU-side Wishbone request arbiter.
package wb_cpu_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} arb_state_t;

  typedef enum logic {PORT_INSTR, PORT_DATA} port_id_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hBAD1BAD1;

endpackage

// File: rtl/wb_rr_arbiter2.sv
// Two-way round-robin grant; last grant only advances when a grant is taken.
module wb_rr_arbiter2
  import wb_cpu_pkg::*;
(
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_req_instr,
  input  logic     i_req_data,
  input  logic     i_take,
  output logic     o_valid,
  output port_id_t o_grant
);

  port_id_t r_last_grant;

  always_comb begin
    o_valid = i_req_instr | i_req_data;
    o_grant = PORT_INSTR;
    if (i_req_instr && i_req_data) begin
      o_grant = (r_last_grant == PORT_INSTR) ? PORT_DATA : PORT_INSTR;
    end else if (i_req_data) begin
      o_grant = PORT_DATA;
    end
  end

  // Reset to DATA so the instruction port wins the first tie.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_grant <= PORT_DATA;
    end else if (i_take) begin
      r_last_grant <= o_grant;
    end
  end

endmodule

// File: rtl/wb_cpu_request_arbiter.sv
// Arbitrates CPU fetch/data ports onto one Wishbone manager request at a time,
// with a start timeout while waiting for the manager to go busy.
module wb_cpu_request_arbiter
  import wb_cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        INSTR_REQ_I,
  input  logic [31:0] INSTR_ADR_I,
  output logic [31:0] INSTR_DAT_O,
  output logic        INSTR_DONE_O,
  output logic        INSTR_ERR_O,
  input  logic        DATA_REQ_I,
  input  logic        DATA_WE_I,
  input  logic [31:0] DATA_ADR_I,
  input  logic [31:0] DATA_WDAT_I,
  input  logic [3:0]  DATA_SEL_I,
  output logic [31:0] DATA_RDAT_O,
  output logic        DATA_DONE_O,
  output logic        DATA_ERR_O,
  output logic        MGR_WRITE_O,
  output logic        MGR_READ_O,
  output logic [31:0] MGR_ADR_O,
  output logic [31:0] MGR_DAT_O,
  output logic [3:0]  MGR_SEL_O,
  input  logic [31:0] MGR_DAT_I,
  input  logic        MGR_BUSY_I
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  arb_state_t    r_state, w_state_nxt;
  port_id_t      r_port;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_we;
  logic [31:0]   r_adr, r_wdat;
  logic [3:0]    r_sel;

  logic          w_arb_valid, w_take, w_finish, w_timeout;
  port_id_t      w_arb_grant;
  logic [31:0]   w_rdata;

  wb_rr_arbiter2 u_arb (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_req_instr (INSTR_REQ_I),
    .i_req_data  (DATA_REQ_I),
    .i_take      (w_take),
    .o_valid     (w_arb_valid),
    .o_grant     (w_arb_grant)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_take      = 1'b0;
    w_finish    = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_arb_valid) begin
          w_take      = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_state_nxt = WAIT_BUSY;
        w_cnt_nxt   = '0;
      end
      WAIT_BUSY: begin
        if (MGR_BUSY_I) begin
          w_state_nxt = WAIT_DONE;
        end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          w_state_nxt = IDLE;
          w_finish    = 1'b1;
          w_timeout   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!MGR_BUSY_I) begin
          w_state_nxt = IDLE;
          w_finish    = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (r_we) begin
      w_rdata = '0;
    end else if (w_timeout) begin
      w_rdata = ERR_DATA;
    end else begin
      w_rdata = MGR_DAT_I;
    end
  end

  // Outputs are registered from the current state, so the manager strobe
  // appears in the cycle after ISSUE and DONE in the cycle after completion.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= IDLE;
      r_port       <= PORT_INSTR;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_adr        <= '0;
      r_wdat       <= '0;
      r_sel        <= '0;
      INSTR_DAT_O  <= '0;
      INSTR_DONE_O <= 1'b0;
      INSTR_ERR_O  <= 1'b0;
      DATA_RDAT_O  <= '0;
      DATA_DONE_O  <= 1'b0;
      DATA_ERR_O   <= 1'b0;
      MGR_WRITE_O  <= 1'b0;
      MGR_READ_O   <= 1'b0;
      MGR_ADR_O    <= '0;
      MGR_DAT_O    <= '0;
      MGR_SEL_O    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;

      if (w_take) begin
        r_port <= w_arb_grant;
        if (w_arb_grant == PORT_DATA) begin
          r_we   <= DATA_WE_I;
          r_adr  <= DATA_ADR_I;
          r_wdat <= DATA_WDAT_I;
          r_sel  <= DATA_SEL_I;
        end else begin
          r_we   <= 1'b0;
          r_adr  <= INSTR_ADR_I;
          r_wdat <= '0;
          r_sel  <= 4'hF;
        end
      end

      MGR_WRITE_O <= (r_state == ISSUE) &&  r_we;
      MGR_READ_O  <= (r_state == ISSUE) && !r_we;

      if (r_state == ISSUE) begin
        MGR_ADR_O <= r_adr;
        MGR_DAT_O <= r_wdat;
        MGR_SEL_O <= r_sel;
      end else if (w_finish) begin
        MGR_ADR_O <= '0;
        MGR_DAT_O <= '0;
        MGR_SEL_O <= '0;
      end

      INSTR_DONE_O <= w_finish && (r_port == PORT_INSTR);
      INSTR_ERR_O  <= w_timeout && (r_port == PORT_INSTR);
      DATA_DONE_O  <= w_finish && (r_port == PORT_DATA);
      DATA_ERR_O   <= w_timeout && (r_port == PORT_DATA);

      if (w_finish && (r_port == PORT_INSTR)) INSTR_DAT_O <= w_rdata;
      if (w_finish && (r_port == PORT_DATA))  DATA_RDAT_O <= w_rdata;
    end
  end

endmodule
